ball_collision_sequencer: RTL and testbench

BALL_COLLISION_SEQUENCER -- requirements
Module: ball_collision_sequencer

---
 rtl/ball_collision_sequencer_pkg.sv | 24 ++
 rtl/ball_collision_sequencer_hit_box_check.sv | 32 +++
 rtl/ball_collision_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ball_collision_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_collision_sequencer_pkg.sv
// Shared game definitions: FSM state type for the collision sequencer,
// coordinate widths and the default player hit-box size.
package game_pkg;

    localparam int PLAYER_W           = 10;  // unsigned player coordinate
    localparam int BALL_W             = 11;  // signed ball coordinate / direction
    localparam int DIFF_W             = 12;  // signed ball-minus-player difference
    localparam int DEFAULT_HIT_RADIUS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAUNCH,
        ST_WAIT,
        ST_COMMIT
    } seq_state_t;

    // Magnitude of a two's-complement difference. Never overflows because
    // ball-minus-player always lies in -2047..1023.
    function automatic logic [DIFF_W-1:0] mag(input logic [DIFF_W-1:0] v);
        return v[DIFF_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ball_collision_sequencer_hit_box_check.sv
// Combinational hit test of the ball snapshot against one player.
//   ball_x, ball_y     : signed ball position (11 bits)
//   player_x, player_y : unsigned player position (10 bits)
//   player_valid       : player takes part in collision
//   hit                : player is inside the square hit box and dx != 0
module hit_box_check
    import game_pkg::*;
#(
    parameter int HIT_RADIUS = DEFAULT_HIT_RADIUS
) (
    input  logic [BALL_W-1:0]   ball_x,
    input  logic [BALL_W-1:0]   ball_y,
    input  logic [PLAYER_W-1:0] player_x,
    input  logic [PLAYER_W-1:0] player_y,
    input  logic                player_valid,
    output logic                hit
);

    localparam logic [DIFF_W-1:0] RAD = DIFF_W'(HIT_RADIUS);

    logic [DIFF_W-1:0] dx;
    logic [DIFF_W-1:0] dy;

    always_comb begin
        // Ball is sign-extended, player zero-extended, to 12 bits.
        dx  = {ball_x[BALL_W-1], ball_x} - {2'b00, player_x};
        dy  = {ball_y[BALL_W-1], ball_y} - {2'b00, player_y};
        // dx == 0 is excluded: the collider divides by dx.
        hit = player_valid && (mag(dx) <= RAD) && (mag(dy) <= RAD) && (dx != '0);
    end

endmodule

// File: rtl/ball_collision_sequencer.sv
// Collision pass sequencer: on frame_tick snapshots the ball, scans the
// players one per cycle through a shared hit test, launches the first hit
// onto an external collider, waits COL_LAT cycles for its result and
// presents the next ball state with a one-cycle upd_valid pulse.
//   frame_tick              : starts a pass (ignored and flagged if busy)
//   player_x/y, player_valid: packed player positions, player i at [10i+9:10i]
//   ball_*                  : current ball state, sampled at frame_tick only
//   col_*                   : collider operands, stable from LAUNCH to COMMIT
//   col_new_*               : collider results
//   upd_valid, upd_*        : next ball state, held between pulses
//   hit, hit_idx            : collision applied and player index
//   busy, overrun           : pass in progress / sticky missed frame_tick
module ball_collision_sequencer
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int HIT_RADIUS  = DEFAULT_HIT_RADIUS,
    parameter int COL_LAT     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic [NUM_PLAYERS*PLAYER_W-1:0] player_x,
    input  logic [NUM_PLAYERS*PLAYER_W-1:0] player_y,
    input  logic [NUM_PLAYERS-1:0]          player_valid,
    input  logic [BALL_W-1:0]               ball_x,
    input  logic [BALL_W-1:0]               ball_y,
    input  logic [BALL_W-1:0]               ball_dir_x,
    input  logic [BALL_W-1:0]               ball_dir_y,
    output logic [BALL_W-1:0]               col_ball_x,
    output logic [BALL_W-1:0]               col_ball_y,
    output logic [BALL_W-1:0]               col_dir_x,
    output logic [BALL_W-1:0]               col_dir_y,
    output logic [PLAYER_W-1:0]             col_player_x,
    output logic [PLAYER_W-1:0]             col_player_y,
    input  logic [BALL_W-1:0]               col_new_x,
    input  logic [BALL_W-1:0]               col_new_y,
    input  logic [BALL_W-1:0]               col_new_dir_x,
    input  logic [BALL_W-1:0]               col_new_dir_y,
    output logic                            upd_valid,
    output logic [BALL_W-1:0]               upd_ball_x,
    output logic [BALL_W-1:0]               upd_ball_y,
    output logic [BALL_W-1:0]               upd_dir_x,
    output logic [BALL_W-1:0]               upd_dir_y,
    output logic                            hit,
    output logic [$clog2(NUM_PLAYERS)-1:0]  hit_idx,
    output logic                            busy,
    output logic                            overrun
);

    localparam int IDX_W = $clog2(NUM_PLAYERS);

    seq_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        wcnt;
    logic              pass_hit;
    logic [BALL_W-1:0] snap_x, snap_y, snap_dx, snap_dy;
    logic [BALL_W-1:0] res_x, res_y, res_dx, res_dy;

    logic [PLAYER_W-1:0] cur_px, cur_py;
    logic                cur_pv;
    logic                cur_hit;

    // Player under test; idx is left untouched on a hit, so the same
    // selection also feeds the collider operands in LAUNCH.
    always_comb begin
        cur_px = '0;
        cur_py = '0;
        cur_pv = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_px = player_x[i*PLAYER_W +: PLAYER_W];
                cur_py = player_y[i*PLAYER_W +: PLAYER_W];
                cur_pv = player_valid[i];
            end
        end
    end

    hit_box_check #(
        .HIT_RADIUS(HIT_RADIUS)
    ) u_hit_box_check (
        .ball_x      (snap_x),
        .ball_y      (snap_y),
        .player_x    (cur_px),
        .player_y    (cur_py),
        .player_valid(cur_pv),
        .hit         (cur_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            wcnt         <= '0;
            pass_hit     <= 1'b0;
            snap_x       <= '0;
            snap_y       <= '0;
            snap_dx      <= '0;
            snap_dy      <= '0;
            res_x        <= '0;
            res_y        <= '0;
            res_dx       <= '0;
            res_dy       <= '0;
            col_ball_x   <= '0;
            col_ball_y   <= '0;
            col_dir_x    <= '0;
            col_dir_y    <= '0;
            col_player_x <= '0;
            col_player_y <= '0;
            upd_valid    <= 1'b0;
            upd_ball_x   <= '0;
            upd_ball_y   <= '0;
            upd_dir_x    <= '0;
            upd_dir_y    <= '0;
            hit          <= 1'b0;
            hit_idx      <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            if (frame_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        snap_x   <= ball_x;
                        snap_y   <= ball_y;
                        snap_dx  <= ball_dir_x;
                        snap_dy  <= ball_dir_y;
                        idx      <= '0;
                        pass_hit <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_hit) begin
                        pass_hit <= 1'b1;
                        state    <= ST_LAUNCH;
                    end else if (idx == IDX_W'(NUM_PLAYERS - 1)) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    col_ball_x   <= snap_x;
                    col_ball_y   <= snap_y;
                    col_dir_x    <= snap_dx;
                    col_dir_y    <= snap_dy;
                    col_player_x <= cur_px;
                    col_player_y <= cur_py;
                    wcnt         <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt == 3'(COL_LAT - 1)) begin
                        res_x  <= col_new_x;
                        res_y  <= col_new_y;
                        res_dx <= col_new_dir_x;
                        res_dy <= col_new_dir_y;
                        state  <= ST_COMMIT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    upd_valid <= 1'b1;
                    hit       <= pass_hit;
                    if (pass_hit) begin
                        upd_ball_x <= res_x;
                        upd_ball_y <= res_y;
                        upd_dir_x  <= res_dx;
                        upd_dir_y  <= res_dy;
                        hit_idx    <= idx;
                    end else begin
                        upd_ball_x <= snap_x;
                        upd_ball_y <= snap_y;
                        upd_dir_x  <= snap_dx;
                        upd_dir_y  <= snap_dy;
                        hit_idx    <= '0;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_sequencer.sv
module tb_ball_collision_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [39:0] player_x, player_y;
    logic [3:0]  player_valid;
    logic [10:0] ball_x, ball_y, ball_dir_x, ball_dir_y;
    logic [10:0] col_ball_x, col_ball_y, col_dir_x, col_dir_y;
    logic [9:0]  col_player_x, col_player_y;
    logic [10:0] col_new_x, col_new_y, col_new_dir_x, col_new_dir_y;
    logic        upd_valid;
    logic [10:0] upd_ball_x, upd_ball_y, upd_dir_x, upd_dir_y;
    logic        hit;
    logic [1:0]  hit_idx;
    logic        busy, overrun;

    ball_collision_sequencer #(
        .NUM_PLAYERS(4),
        .HIT_RADIUS (16),
        .COL_LAT    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .player_x     (player_x),
        .player_y     (player_y),
        .player_valid (player_valid),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_dir_x   (ball_dir_x),
        .ball_dir_y   (ball_dir_y),
        .col_ball_x   (col_ball_x),
        .col_ball_y   (col_ball_y),
        .col_dir_x    (col_dir_x),
        .col_dir_y    (col_dir_y),
        .col_player_x (col_player_x),
        .col_player_y (col_player_y),
        .col_new_x    (col_new_x),
        .col_new_y    (col_new_y),
        .col_new_dir_x(col_new_dir_x),
        .col_new_dir_y(col_new_dir_y),
        .upd_valid    (upd_valid),
        .upd_ball_x   (upd_ball_x),
        .upd_ball_y   (upd_ball_y),
        .upd_dir_x    (upd_dir_x),
        .upd_dir_y    (upd_dir_y),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Collider stub: x+3, y-2, reflect dir_x, dir_y+1.
    always_comb begin
        col_new_x     = col_ball_x + 11'd3;
        col_new_y     = col_ball_y - 11'd2;
        col_new_dir_x = 11'd0 - col_dir_x;
        col_new_dir_y = col_dir_y + 11'd1;
    end

    typedef struct {
        logic        hit;
        logic [1:0]  idx;
        logic [10:0] x, y, dx, dy;
        logic [9:0]  cpx, cpy;
        int          lat;
        int          tick;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every upd_valid pulse must match the oldest expected pass.
    always @(negedge clk) begin
        if (!rst && upd_valid) begin
            if (q.size() == 0) begin
                chk("upd_valid_unexpected", 32'(upd_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 32'(cyc - e.tick), 32'(e.lat));
                chk("hit", 32'(hit), 32'(e.hit));
                chk("hit_idx", 32'(hit_idx), 32'(e.idx));
                chk("upd_ball_x", 32'(upd_ball_x), 32'(e.x));
                chk("upd_ball_y", 32'(upd_ball_y), 32'(e.y));
                chk("upd_dir_x", 32'(upd_dir_x), 32'(e.dx));
                chk("upd_dir_y", 32'(upd_dir_y), 32'(e.dy));
                if (e.hit) begin
                    chk("col_player_x", 32'(col_player_x), 32'(e.cpx));
                    chk("col_player_y", 32'(col_player_y), 32'(e.cpy));
                end
            end
        end
    end

    function automatic logic [39:0] pk(input logic [9:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic exp_t mk(input logic h, input logic [1:0] idx,
                                input logic [10:0] x, y, dx, dy,
                                input logic [9:0] cpx, cpy, input int lat);
        exp_t e;
        e.hit = h; e.idx = idx; e.x = x; e.y = y; e.dx = dx; e.dy = dy;
        e.cpx = cpx; e.cpy = cpy; e.lat = lat; e.tick = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the tick.
    task automatic issue(input logic [10:0] bx, by, bdx, bdy,
                         input logic [39:0] px, py, input logic [3:0] pv,
                         input exp_t e, input bit push);
        ball_x = bx; ball_y = by; ball_dir_x = bdx; ball_dir_y = bdy;
        player_x = px; player_y = py; player_valid = pv;
        e.tick = cyc;
        if (push) begin
            q.push_back(e);
            last_exp = e;
        end
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            chk("upd_valid_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        chk("hold_upd_ball_x", 32'(upd_ball_x), 32'(last_exp.x));
        chk("hold_hit", 32'(hit), 32'(last_exp.hit));
    endtask

    task automatic run(input logic [10:0] bx, by, bdx, bdy,
                       input logic [39:0] px, py, input logic [3:0] pv, input exp_t e);
        issue(bx, by, bdx, bdy, px, py, pv, e, 1'b1);
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_hit"}, 32'({hit, hit_idx}), 32'd0);
        chk({tag, "_upd"}, 32'(upd_ball_x | upd_ball_y | upd_dir_x | upd_dir_y), 32'd0);
        chk({tag, "_col"}, 32'(col_ball_x | col_ball_y | col_dir_x | col_dir_y), 32'd0);
        chk({tag, "_col_player"}, 32'(col_player_x | col_player_y), 32'd0);
    endtask

    localparam logic [9:0] FAR = 10'd300;

    initial begin
        rst = 1'b1; frame_tick = 1'b0;
        ball_x = '0; ball_y = '0; ball_dir_x = '0; ball_dir_y = '0;
        player_x = '0; player_y = '0; player_valid = '0;
        last_exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // No hit: all players far away.
        issue(100, 100, 3, -11'sd2, pk(FAR, FAR, FAR, FAR), pk(FAR, FAR, FAR, FAR), 4'hF,
              mk(0, 0, 100, 100, 3, -11'sd2, 0, 0, 6), 1'b1);
        chk("busy_in_pass", 32'(busy), 32'd1);
        wait_done();

        // Priority: players 1 and 3 both hit, lowest index wins.
        run(100, 100, 3, -11'sd2, pk(FAR, 95, FAR, 95), pk(FAR, 90, FAR, 90), 4'hF,
            mk(1, 1, 103, 98, -11'sd3, -11'sd1, 95, 90, 7));
        // Radius boundary dx=16, dy=-16 hits.
        run(100, 100, 3, -11'sd2, pk(84, FAR, FAR, FAR), pk(116, FAR, FAR, FAR), 4'hF,
            mk(1, 0, 103, 98, -11'sd3, -11'sd1, 84, 116, 6));
        // dx=17 misses.
        run(100, 100, 3, -11'sd2, pk(83, FAR, FAR, FAR), pk(100, FAR, FAR, FAR), 4'hF,
            mk(0, 0, 100, 100, 3, -11'sd2, 0, 0, 6));
        // dx=0, dy=5 misses.
        run(100, 100, 3, -11'sd2, pk(100, FAR, FAR, FAR), pk(95, FAR, FAR, FAR), 4'hF,
            mk(0, 0, 100, 100, 3, -11'sd2, 0, 0, 6));
        // dx=0 player skipped, player 2 at dx=10 hits.
        run(100, 100, 3, -11'sd2, pk(100, FAR, 90, FAR), pk(95, FAR, 100, FAR), 4'hF,
            mk(1, 2, 103, 98, -11'sd3, -11'sd1, 90, 100, 8));
        // Invalid player inside the box is ignored.
        run(101, 100, 3, -11'sd2, pk(100, FAR, FAR, FAR), pk(100, FAR, FAR, FAR), 4'b1110,
            mk(0, 0, 101, 100, 3, -11'sd2, 0, 0, 6));
        // Negative ball x: dx = -5 - 10 = -15 hits.
        run(-11'sd5, 3, 1, 1, pk(10, FAR, FAR, FAR), pk(0, FAR, FAR, FAR), 4'hF,
            mk(1, 0, -11'sd2, 1, -11'sd1, 2, 10, 0, 6));

        chk("overrun_before", 32'(overrun), 32'd0);
        // Overrun during WAIT, with ball inputs disturbed mid-pass.
        issue(100, 100, 3, -11'sd2, pk(95, FAR, FAR, FAR), pk(90, FAR, FAR, FAR), 4'hF,
              mk(1, 0, 103, 98, -11'sd3, -11'sd1, 95, 90, 6), 1'b1);
        ball_x = 500; ball_y = 500; ball_dir_x = 9; ball_dir_y = 9;
        @(posedge clk); #1;   // LAUNCH
        @(posedge clk); #1;   // WAIT
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_set", 32'(overrun), 32'd1);

        // Reset in the middle of WAIT: pass aborted, no upd_valid.
        issue(100, 100, 3, -11'sd2, pk(95, FAR, FAR, FAR), pk(90, FAR, FAR, FAR), 4'hF,
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;   // LAUNCH
        @(posedge clk); #1;   // WAIT
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midreset");
        repeat (12) @(posedge clk);
        #1;
        chk("midreset_idle", 32'(busy), 32'd0);

        // Normal pass after the aborted one.
        run(100, 100, 3, -11'sd2, pk(FAR, 95, FAR, 95), pk(FAR, 90, FAR, 90), 4'hF,
            mk(1, 1, 103, 98, -11'sd3, -11'sd1, 95, 90, 7));
        chk("overrun_after_reset", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
